cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 142 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per functional unit, round-robin
// selection of one result per cycle onto a registered broadcast bus.
module cdb_arbiter #(
   parameter int ROBsize    = 32,
   parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [3:0]                   fuValid_i,
   input  logic [3:0][ROBsizeLog-1:0]   fuTag_i,
   input  logic [3:0][63:0]             fuData_i,
   output logic [3:0]                   fuReady_o,
   input  logic                         flush_i,
   output logic                         cdbValid_o,
   output logic [ROBsizeLog-1:0]        cdbTag_o,
   output logic [63:0]                  cdbData_o,
   output logic [1:0]                   cdbSource_o,
   output logic [2:0]                   busyCount_o
);

   localparam int NUM_FU = 4;

   // Holding slots
   logic [NUM_FU-1:0]                  full_q, full_d;
   logic [NUM_FU-1:0][ROBsizeLog-1:0]  tag_q, tag_d;
   logic [NUM_FU-1:0][63:0]            data_q, data_d;

   // Arbitration and broadcast state
   logic [1:0]             rr_ptr_q, rr_ptr_d;
   logic                   cdb_valid_q, cdb_valid_d;
   logic [ROBsizeLog-1:0]  cdb_tag_q, cdb_tag_d;
   logic [63:0]            cdb_data_q, cdb_data_d;
   logic [1:0]             cdb_source_q, cdb_source_d;
   logic [2:0]             busy_q, busy_d;

   logic                   grant_vld;
   logic [1:0]             grant_idx;
   logic [NUM_FU-1:0]      grant;
   logic [NUM_FU-1:0]      accept;

   // Round-robin search: walking offsets from 3 down to 0 leaves the
   // nearest full slot to rr_ptr_q as the final assignment.
   always_comb begin
      logic [1:0] idx;
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      grant_vld = 1'b0;
      grant_idx = rr_ptr_q;
      idx       = rr_ptr_q;
      for (int k = NUM_FU - 1; k >= 0; k--) begin
         idx = rr_ptr_q + 2'(k);
         if (full_q[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
         end
      end
      if (flush_i) begin
         grant_vld = 1'b0;
      end
   end

   assign grant     = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
   assign fuReady_o = {NUM_FU{~flush_i}} & (~full_q | grant);
   assign accept    = fuValid_i & fuReady_o;

   // Slot next-state: a granted slot drains, an accepted non-zero tag loads
   // (reloading a draining slot on the same edge).
   always_comb begin
      full_d = full_q;
      tag_d  = tag_q;
      data_d = data_q;
      if (flush_i) begin
         full_d = '0;
      end else begin
         for (int g = 0; g < NUM_FU; g++) begin
            if (grant[g]) begin
               full_d[g] = 1'b0;
            end
            if (accept[g] && (fuTag_i[g] != '0)) begin
               full_d[g] = 1'b1;
               tag_d[g]  = fuTag_i[g];
               data_d[g] = fuData_i[g];
            end
         end
      end
   end

   // Broadcast next-state: tag/data/source/pointer hold when nothing is granted.
   always_comb begin
      cdb_valid_d  = 1'b0;
      cdb_tag_d    = cdb_tag_q;
      cdb_data_d   = cdb_data_q;
      cdb_source_d = cdb_source_q;
      rr_ptr_d     = rr_ptr_q;
      if (grant_vld) begin
         cdb_valid_d  = 1'b1;
         cdb_tag_d    = tag_q[grant_idx];
         cdb_data_d   = data_q[grant_idx];
         cdb_source_d = grant_idx;
         rr_ptr_d     = grant_idx + 2'd1;
      end
   end

   assign busy_d = 3'(full_d[0]) + 3'(full_d[1]) + 3'(full_d[2]) + 3'(full_d[3]);

   // Control state
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         full_q       <= '0;
         rr_ptr_q     <= 2'd0;
         cdb_valid_q  <= 1'b0;
         cdb_tag_q    <= '0;
         cdb_data_q   <= '0;
         cdb_source_q <= 2'd0;
         busy_q       <= 3'd0;
      end else begin
         full_q       <= full_d;
         rr_ptr_q     <= rr_ptr_d;
         cdb_valid_q  <= cdb_valid_d;
         cdb_tag_q    <= cdb_tag_d;
         cdb_data_q   <= cdb_data_d;
         cdb_source_q <= cdb_source_d;
         busy_q       <= busy_d;
      end
   end

   // NOTE: slot payload is not reset; it is only ever read while its full
   // flag is set, so resetting it would add reset fan-out for no benefit.
   always_ff @(posedge clk_i) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign cdbValid_o  = cdb_valid_q;
   assign cdbTag_o    = cdb_tag_q;
   assign cdbData_o   = cdb_data_q;
   assign cdbSource_o = cdb_source_q;
   assign busyCount_o = busy_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic compared against a slot/queue-level reference model.
module tb_cdb_arbiter;

   localparam int ROB = 32;
   localparam int W   = $clog2(ROB + 1);

   logic                 clk = 1'b0;
   logic                 rst;
   logic [3:0]           fu_valid;
   logic [3:0][W-1:0]    fu_tag;
   logic [3:0][63:0]     fu_data;
   logic [3:0]           fu_ready;
   logic                 flush;
   logic                 cdb_valid;
   logic [W-1:0]         cdb_tag;
   logic [63:0]          cdb_data;
   logic [1:0]           cdb_source;
   logic [2:0]           busy_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(.ROBsize(ROB)) dut (
      .clk_i      (clk),
      .reset_i    (rst),
      .fuValid_i  (fu_valid),
      .fuTag_i    (fu_tag),
      .fuData_i   (fu_data),
      .fuReady_o  (fu_ready),
      .flush_i    (flush),
      .cdbValid_o (cdb_valid),
      .cdbTag_o   (cdb_tag),
      .cdbData_o  (cdb_data),
      .cdbSource_o(cdb_source),
      .busyCount_o(busy_count)
   );

   wire [75:0] dut_out = {cdb_valid, cdb_tag, cdb_data, cdb_source, busy_count};

   // Reference model state
   bit           m_full [4];
   logic [W-1:0] m_tag  [4];
   logic [63:0]  m_data [4];
   int           m_rr;
   bit           m_valid;
   logic [W-1:0] m_ctag;
   logic [63:0]  m_cdata;
   int           m_src;
   int           m_busy;

   function automatic int m_winner();
      if (flush) return -1;
      for (int k = 0; k < 4; k++) begin
         if (m_full[(m_rr + k) % 4]) return (m_rr + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] m_ready();
      logic [3:0] r;
      int w;
      w = m_winner();
      for (int g = 0; g < 4; g++) r[g] = !flush && (!m_full[g] || g == w);
      return r;
   endfunction

   function automatic logic [75:0] m_out();
      return {m_valid, m_ctag, m_cdata, 2'(m_src), 3'(m_busy)};
   endfunction

   task automatic model_reset();
      for (int g = 0; g < 4; g++) m_full[g] = 0;
      m_rr = 0; m_valid = 0; m_ctag = '0; m_cdata = '0; m_src = 0; m_busy = 0;
   endtask

   task automatic model_edge();
      logic [3:0] r;
      int w;
      r = m_ready();
      w = m_winner();
      if (flush) begin
         for (int g = 0; g < 4; g++) m_full[g] = 0;
         m_valid = 0;
      end else begin
         if (w >= 0) begin
            m_valid = 1; m_ctag = m_tag[w]; m_cdata = m_data[w]; m_src = w;
            m_rr = (w + 1) % 4; m_full[w] = 0;
         end else begin
            m_valid = 0;
         end
         for (int g = 0; g < 4; g++) begin
            if (fu_valid[g] && r[g] && fu_tag[g] != 0) begin
               m_full[g] = 1; m_tag[g] = fu_tag[g]; m_data[g] = fu_data[g];
            end
         end
      end
      m_busy = 0;
      for (int g = 0; g < 4; g++) m_busy += int'(m_full[g]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      fu_valid = 4'b0000;
      flush    = 1'b0;
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b1;
      model_reset();
      #2 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      fu_tag  = '0;
      fu_data = '0;
      model_reset();
      #12;
      n_tests++;
      if (dut_out !== 76'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected 0", dut_out);
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (fu_ready !== 4'b1111) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 1111", fu_ready);
      end
      tick();
   endtask

   task automatic test_single();
      fu_valid = 4'b0100; fu_tag[2] = W'(5); fu_data[2] = 64'hAB;
      tick();
      idle();
      n_tests++;
      if (cdb_valid !== 1'b0 || busy_count !== 3'd1) begin
         n_fail++; $display("FAIL single_load: valid %b busy %0d expected 0 1", cdb_valid, busy_count);
      end
      tick();
      n_tests++;
      if ({cdb_valid, cdb_tag, cdb_data, cdb_source} !== {1'b1, W'(5), 64'hAB, 2'd2}) begin
         n_fail++;
         $display("FAIL single_bcast: got v%b t%0d d%h s%0d expected v1 t5 dab s2",
                  cdb_valid, cdb_tag, cdb_data, cdb_source);
      end
      tick();
      n_tests++;
      if (cdb_valid !== 1'b0 || dut_out !== m_out()) begin
         n_fail++; $display("FAIL single_after: got %h expected %h", dut_out, m_out());
      end
   endtask

   task automatic test_round_robin();
      pulse_reset();
      fu_valid = 4'b1111;
      for (int g = 0; g < 4; g++) begin
         fu_tag[g] = W'(g + 1); fu_data[g] = 64'h1000 + 64'(g);
      end
      #1;
      n_tests++;
      if (fu_ready !== 4'b1111) begin
         n_fail++; $display("FAIL rr_ready_empty: got %b expected 1111", fu_ready);
      end
      tick();
      for (int k = 0; k < 8; k++) begin
         n_tests++;
         if (fu_ready !== (4'b0001 << (k % 4))) begin
            n_fail++; $display("FAIL rr_ready_%0d: got %b expected %b", k, fu_ready, 4'b0001 << (k % 4));
         end
         tick();
         n_tests++;
         if (cdb_source !== 2'(k % 4) || busy_count !== 3'd4 || dut_out !== m_out()) begin
            n_fail++; $display("FAIL rr_bcast_%0d: got %h expected %h (src %0d)", k, dut_out, m_out(), k % 4);
         end
      end
      idle();
   endtask

   task automatic test_tag_zero();
      pulse_reset();
      fu_valid = 4'b0010; fu_tag[1] = '0; fu_data[1] = 64'hDEAD;
      #1;
      n_tests++;
      if (fu_ready[1] !== 1'b1) begin
         n_fail++; $display("FAIL tag0_ready: got %b expected 1", fu_ready[1]);
      end
      tick();
      idle();
      n_tests++;
      if (busy_count !== 3'd0) begin
         n_fail++; $display("FAIL tag0_busy: got %0d expected 0", busy_count);
      end
      tick();
      n_tests++;
      if (cdb_valid !== 1'b0 || busy_count !== 3'd0) begin
         n_fail++; $display("FAIL tag0_nobcast: valid %b busy %0d expected 0 0", cdb_valid, busy_count);
      end
   endtask

   task automatic test_flush();
      fu_valid = 4'b0111;
      for (int g = 0; g < 3; g++) begin
         fu_tag[g] = W'(9 + g); fu_data[g] = 64'h9000 + 64'(g);
      end
      tick();
      n_tests++;
      if (busy_count !== 3'd3) begin
         n_fail++; $display("FAIL flush_loaded: got %0d expected 3", busy_count);
      end
      flush = 1'b1; fu_valid = 4'b1000; fu_tag[3] = W'(12);
      #1;
      n_tests++;
      if (fu_ready !== 4'b0000) begin
         n_fail++; $display("FAIL flush_ready: got %b expected 0000", fu_ready);
      end
      tick();
      idle();
      n_tests++;
      if (busy_count !== 3'd0 || cdb_valid !== 1'b0 || dut_out !== m_out()) begin
         n_fail++; $display("FAIL flush_clear: got %h expected %h", dut_out, m_out());
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         n_tests++;
         if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_leak_%0d: got valid %b tag %0d expected no broadcast", k, cdb_valid, cdb_tag);
         end
      end
   endtask

   task automatic test_wrap();
      pulse_reset();
      fu_valid = 4'b0100; fu_tag[2] = W'(20); fu_data[2] = 64'h20;
      tick();
      fu_valid = 4'b1001;
      fu_tag[0] = W'(21); fu_data[0] = 64'h21;
      fu_tag[3] = W'(22); fu_data[3] = 64'h22;
      tick();
      idle();
      n_tests++;
      if (cdb_source !== 2'd2 || cdb_valid !== 1'b1) begin
         n_fail++; $display("FAIL wrap_setup: got src %0d valid %b expected 2 1", cdb_source, cdb_valid);
      end
      tick();
      n_tests++;
      if (cdb_source !== 2'd3 || cdb_tag !== W'(22) || dut_out !== m_out()) begin
         n_fail++; $display("FAIL wrap_first: got %h expected src 3 tag 22 (%h)", dut_out, m_out());
      end
      tick();
      n_tests++;
      if (cdb_source !== 2'd0 || cdb_tag !== W'(21) || dut_out !== m_out()) begin
         n_fail++; $display("FAIL wrap_second: got %h expected src 0 tag 21 (%h)", dut_out, m_out());
      end
      fu_valid = 4'b0011;
      fu_tag[0] = W'(23); fu_data[0] = 64'h23;
      fu_tag[1] = W'(24); fu_data[1] = 64'h24;
      tick();
      idle();
      tick();
      n_tests++;
      if (cdb_source !== 2'd1 || cdb_tag !== W'(24)) begin
         n_fail++; $display("FAIL wrap_ptr1: got src %0d tag %0d expected 1 24", cdb_source, cdb_tag);
      end
      tick();
      n_tests++;
      if (cdb_source !== 2'd0 || cdb_tag !== W'(23)) begin
         n_fail++; $display("FAIL wrap_after: got src %0d tag %0d expected 0 23", cdb_source, cdb_tag);
      end
   endtask

   task automatic test_reset_mid();
      fu_valid = 4'b1111;
      for (int g = 0; g < 4; g++) begin
         fu_tag[g] = W'(25 + g); fu_data[g] = 64'h2500 + 64'(g);
      end
      tick();
      tick();
      idle();
      #3 rst = 1'b1;
      model_reset();
      #1;
      n_tests++;
      if (dut_out !== 76'd0) begin
         n_fail++; $display("FAIL midreset_outputs: got %h expected 0", dut_out);
      end
      #1 rst = 1'b0;
      #1;
      n_tests++;
      if (fu_ready !== 4'b1111) begin
         n_fail++; $display("FAIL midreset_ready: got %b expected 1111", fu_ready);
      end
      @(negedge clk);
      fu_valid = 4'b1000; fu_tag[3] = W'(7); fu_data[3] = 64'h7777;
      tick();
      idle();
      tick();
      n_tests++;
      if ({cdb_valid, cdb_tag, cdb_source} !== {1'b1, W'(7), 2'd3} || dut_out !== m_out()) begin
         n_fail++; $display("FAIL midreset_first: got %h expected src 3 tag 7 (%h)", dut_out, m_out());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         fu_valid = 4'($urandom);
         for (int g = 0; g < 4; g++) begin
            fu_tag[g]  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, ROB));
            fu_data[g] = {$urandom, $urandom};
         end
         flush = ($urandom_range(0, 15) == 0);
         #1;
         n_tests++;
         if (fu_ready !== m_ready()) begin
            n_fail++; $display("FAIL rand_ready_%0d: got %b expected %b", i, fu_ready, m_ready());
         end
         tick();
         n_tests++;
         if (dut_out !== m_out()) begin
            n_fail++; $display("FAIL rand_out_%0d: got %h expected %h", i, dut_out, m_out());
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_tag_zero();
      test_flush();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
